mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 23 ++
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   state_t      - arbiter FSM state encoding
//   PORT0/PORT1  - port index constants (also the encoding of last-grant)
//   MEM_LAT_DEF  - default read latency of the shared memory, in cycles
//   lat_load()   - reload value for the 3-bit read-latency down-counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DATA_W      = 16;
  localparam int MEM_LAT_DEF = 2;

  // The counter runs from MEM_LAT-1 down to 0 while in WAIT, so WAIT lasts
  // exactly MEM_LAT cycles and the data is captured in its last cycle.
  function automatic logic [2:0] lat_load(input int lat);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter, purely combinational.
//   req[1:0]    - request bits, index = port
//   last_grant  - port that won the previous counted arbitration
//   grant[1:0]  - one-hot grant (all zero when nobody requests)
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      // Tie: the port that did not win last time goes first.
      grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-side port (0)
// and a data-side port (1). One transaction is in flight at a time.
//   clk, rst                       - clock, asynchronous active-high reset
//   Addr*/DataIn*/Rd*/Wr*          - per-port request, held until Done*
//   DataOut*/Done*/Stall*/err*     - per-port response (Done is a 1-cycle pulse)
//   mem_addr/mem_data_in/mem_rd/mem_wr - shared memory request
//   mem_data_out/mem_stall/mem_err - shared memory response
// Parameter MEM_LAT (1..7): cycles from an accepted read to valid mem_data_out.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr0,
  input  logic [15:0] DataIn0,
  input  logic        Rd0,
  input  logic        Wr0,
  output logic [15:0] DataOut0,
  output logic        Done0,
  output logic        Stall0,
  output logic        err0,
  input  logic [15:0] Addr1,
  input  logic [15:0] DataIn1,
  input  logic        Rd1,
  input  logic        Wr1,
  output logic [15:0] DataOut1,
  output logic        Done1,
  output logic        Stall1,
  output logic        err1,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_err
);

  localparam logic [2:0] LAT_LOAD = lat_load(MEM_LAT);

  state_t                   state;
  logic                     gnt_port;
  logic                     op_wr;
  logic                     op_bad;
  logic                     err_acc;
  logic                     last_gnt;
  logic        [DATA_W-1:0] addr_q;
  logic        [DATA_W-1:0] wdata_q;
  logic        [2:0]        lat_cnt;
  logic                     done0_q;
  logic                     done1_q;
  logic                     err0_q;
  logic                     err1_q;
  logic        [DATA_W-1:0] dout0_q;
  logic        [DATA_W-1:0] dout1_q;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              have_grant;
  logic              sel_port;
  logic              sel_rd;
  logic              sel_wr;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_data;

  assign req = {Rd1 | Wr1, Rd0 | Wr0};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_gnt),
    .grant      (grant)
  );

  assign have_grant = |grant;
  assign sel_port   = grant[1];
  assign sel_rd     = sel_port ? Rd1 : Rd0;
  assign sel_wr     = sel_port ? Wr1 : Wr0;

  // fin marks the last cycle of a transaction: the next state is DONE and
  // the port response registers load from fin_err/fin_data.
  always_comb begin
    fin      = 1'b0;
    fin_err  = err_acc;
    fin_data = '0;
    case (state)
      ISSUE: begin
        if (op_bad) begin
          // Rd and Wr both high: no memory access, just report the error.
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (!mem_stall && op_wr) begin
          fin     = 1'b1;
          fin_err = err_acc | mem_err;
        end
      end
      WAIT: begin
        if (lat_cnt == 3'd0) begin
          fin      = 1'b1;
          fin_err  = err_acc | mem_err;
          fin_data = mem_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_port <= PORT0;
      op_wr    <= 1'b0;
      op_bad   <= 1'b0;
      err_acc  <= 1'b0;
      last_gnt <= PORT1;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_cnt  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      dout0_q  <= '0;
      dout1_q  <= '0;
    end else begin
      done0_q <= fin && (gnt_port == PORT0);
      done1_q <= fin && (gnt_port == PORT1);
      err0_q  <= fin && (gnt_port == PORT0) && fin_err;
      err1_q  <= fin && (gnt_port == PORT1) && fin_err;
      dout0_q <= (fin && (gnt_port == PORT0)) ? fin_data : '0;
      dout1_q <= (fin && (gnt_port == PORT1)) ? fin_data : '0;

      case (state)
        IDLE: begin
          if (have_grant) begin
            gnt_port <= sel_port;
            op_wr    <= sel_wr;
            op_bad   <= sel_rd & sel_wr;
            addr_q   <= sel_port ? Addr1 : Addr0;
            wdata_q  <= sel_port ? DataIn1 : DataIn0;
            err_acc  <= 1'b0;
            lat_cnt  <= '0;
            // An illegal request is served but does not move the
            // round-robin pointer.
            if (!(sel_rd && sel_wr)) begin
              last_gnt <= sel_port;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!op_bad && mem_err) begin
            err_acc <= 1'b1;
          end
          if (fin) begin
            state <= DONE;
          end else if (!mem_stall) begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_err) begin
            err_acc <= 1'b1;
          end
          if (fin) begin
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign DataOut0 = dout0_q;
  assign DataOut1 = dout1_q;
  assign Done0    = done0_q;
  assign Done1    = done1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;

  // Stall is combinational from the requests, forced low while in reset.
  assign Stall0 = ~rst & (Rd0 | Wr0) & ~done0_q;
  assign Stall1 = ~rst & (Rd1 | Wr1) & ~done1_q;

  assign mem_rd      = (state == ISSUE) & ~op_bad & ~op_wr;
  assign mem_wr      = (state == ISSUE) & ~op_bad & op_wr;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

endmodule
